// File: rtl/mult_accumulator.sv
// -----------------------------------------------------------------------------
// mult_accumulator
//
// Batch accumulator that sits behind the 4x4 array multiplier. It takes the
// 8-bit unsigned product stream over a valid/ready handshake and adds BATCH
// consecutive products into a saturating ACC_W-bit accumulator. The finished
// batch is offered on a registered valid/ready port together with a sticky
// overflow flag. Once the consumer takes it, the next batch starts.
//
// Parameters
//   BATCH     products per result (1..255)
//   ACC_W     accumulator width   (8..24)
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   asynchronous, active-high reset
//   clear      in   synchronous abort of the current batch / pending result
//   prod       in   [7:0] unsigned product
//   in_valid   in   prod is valid this cycle
//   in_ready   out  block accepts prod this cycle (ACCUM state, not in reset)
//   sum        out  [ACC_W-1:0] batch result, stable while out_valid=1
//   ovf        out  batch saturated, qualified by out_valid
//   out_valid  out  sum/ovf hold a completed batch (DRAIN state)
//   out_ready  in   consumer takes the result this cycle
//   cnt        out  [7:0] products accepted in the current batch
// -----------------------------------------------------------------------------
module mult_accumulator #(
    parameter int BATCH = 4,
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [7:0]       prod,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] sum,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       cnt
);

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [7:0]       LAST_CNT = 8'(BATCH - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = '1;

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [7:0]       r_cnt;

    logic             w_accept;
    logic [ACC_W:0]   w_sat;

    // Saturating add. The product is zero-extended to ACC_W+1 bits so the
    // carry out of bit ACC_W-1 lands in the top bit; a carry clamps the sum
    // to full scale. The returned top bit is the saturation indicator.
    function automatic logic [ACC_W:0] add_sat(input logic [ACC_W-1:0] acc,
                                               input logic [7:0]       p);
        logic [ACC_W:0] w_ext;
        w_ext = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, p};
        if (w_ext[ACC_W]) begin
            return {1'b1, ACC_MAX};
        end
        return w_ext;
    endfunction

    // in_valid is only looked at in ACCUM; DRAIN ignores the upstream word.
    assign w_accept = in_valid && (r_state == ACCUM);
    assign w_sat    = add_sat(r_acc, prod);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ACCUM;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else if (clear) begin
            // Abort: any product offered this cycle and any pending result
            // are dropped.
            r_state <= ACCUM;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_sat[ACC_W-1:0];
                        r_ovf <= r_ovf | w_sat[ACC_W];
                        if (r_cnt == LAST_CNT) begin
                            r_cnt   <= '0;
                            r_state <= DRAIN;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        r_acc   <= '0;
                        r_ovf   <= 1'b0;
                        r_state <= ACCUM;
                    end
                end
            endcase
        end
    end

    // Outputs come straight from registers or the state decode. in_ready is
    // also held low while rst is asserted.
    assign in_ready  = (r_state == ACCUM) && !rst;
    assign out_valid = (r_state == DRAIN);
    assign sum       = r_acc;
    assign ovf       = r_ovf;
    assign cnt       = r_cnt;

endmodule

// File: tb/tb_mult_accumulator.sv
// -----------------------------------------------------------------------------
// tb_mult_accumulator
//
// Two instances: u0 (BATCH=4, ACC_W=12) and u1 (BATCH=8, ACC_W=10). Each cycle
// both are compared with a reference model that only tracks the running
// arithmetic total of accepted products, how many were accepted and whether a
// result is pending. The expected result is min(total, 2^ACC_W-1) and the
// overflow flag is total > 2^ACC_W-1.
// -----------------------------------------------------------------------------
module tb_mult_accumulator;

    localparam int BA = 4;
    localparam int WA = 12;
    localparam int BB = 8;
    localparam int WB = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr  [2];
    logic        iv   [2];
    logic        ordy [2];
    logic [7:0]  pr   [2];
    logic        ir   [2];
    logic        ov   [2];
    logic        of   [2];
    logic [7:0]  cn   [2];
    logic [WA-1:0] sa;
    logic [WB-1:0] sb;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    int m_tot   [2];
    int m_n     [2];
    bit m_drain [2];
    int m_bat   [2] = '{BA, BB};
    int m_max   [2] = '{(1 << WA) - 1, (1 << WB) - 1};

    mult_accumulator #(.BATCH(BA), .ACC_W(WA)) u0 (
        .clk(clk), .rst(rst), .clear(clr[0]), .prod(pr[0]), .in_valid(iv[0]),
        .in_ready(ir[0]), .sum(sa), .ovf(of[0]), .out_valid(ov[0]),
        .out_ready(ordy[0]), .cnt(cn[0])
    );

    mult_accumulator #(.BATCH(BB), .ACC_W(WB)) u1 (
        .clk(clk), .rst(rst), .clear(clr[1]), .prod(pr[1]), .in_valid(iv[1]),
        .in_ready(ir[1]), .sum(sb), .ovf(of[1]), .out_valid(ov[1]),
        .out_ready(ordy[1]), .cnt(cn[1])
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int sum_of(input int k);
        return (k == 0) ? int'(sa) : int'(sb);
    endfunction

    function automatic int m_res(input int k);
        return (m_tot[k] > m_max[k]) ? m_max[k] : m_tot[k];
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_tot[k]   = 0;
            m_n[k]     = 0;
            m_drain[k] = 1'b0;
        end
    endtask

    task automatic idle();
        for (int k = 0; k < 2; k++) begin
            clr[k]  = 1'b0;
            iv[k]   = 1'b0;
            ordy[k] = 1'b1;
            pr[k]   = 8'($urandom_range(0, 255));
        end
    endtask

    // One clock: compare both DUTs against the model at the falling edge,
    // advance the model with the inputs seen at the rising edge.
    task automatic cyc();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("u%0d.in_ready", k), int'(ir[k]), int'(!m_drain[k]));
            chk($sformatf("u%0d.out_valid", k), int'(ov[k]), int'(m_drain[k]));
            chk($sformatf("u%0d.cnt", k), int'(cn[k]), m_n[k]);
            if (m_drain[k]) begin
                chk($sformatf("u%0d.sum", k), sum_of(k), m_res(k));
                chk($sformatf("u%0d.ovf", k), int'(of[k]), int'(m_tot[k] > m_max[k]));
            end
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (clr[k]) begin
                m_tot[k]   = 0;
                m_n[k]     = 0;
                m_drain[k] = 1'b0;
            end else if (m_drain[k]) begin
                if (ordy[k]) begin
                    m_drain[k] = 1'b0;
                    m_tot[k]   = 0;
                end
            end else if (iv[k]) begin
                m_tot[k] += int'(pr[k]);
                m_n[k]++;
                if (m_n[k] == m_bat[k]) begin
                    m_n[k]     = 0;
                    m_drain[k] = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic feed(input int k, input int p);
        iv[k] = 1'b1;
        pr[k] = 8'(p);
        cyc();
        iv[k] = 1'b0;
    endtask

    task automatic flush(input int k);
        clr[k] = 1'b1;
        cyc();
        clr[k] = 1'b0;
    endtask

    // Asynchronous reset pulse between clock edges; outputs are checked
    // before any further edge.
    task automatic rst_pulse(input string tag);
        #1 rst = 1'b1;
        #1;
        chk({tag, ".out_valid"}, int'(ov[0]), 0);
        chk({tag, ".sum"}, int'(sa), 0);
        chk({tag, ".cnt"}, int'(cn[0]), 0);
        chk({tag, ".in_ready"}, int'(ir[0]), 0);
        #1 rst = 1'b0;
        m_reset();
    endtask

    int gv [7] = '{1, 0, 0, 1, 0, 1, 1};
    int gp [7] = '{10, 0, 0, 20, 0, 30, 40};
    int gc [6] = '{1, 1, 1, 2, 2, 3};

    initial begin
        idle();
        m_reset();

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst.u%0d.in_ready", k), int'(ir[k]), 0);
            chk($sformatf("rst.u%0d.out_valid", k), int'(ov[k]), 0);
            chk($sformatf("rst.u%0d.cnt", k), int'(cn[k]), 0);
            chk($sformatf("rst.u%0d.ovf", k), int'(of[k]), 0);
        end
        chk("rst.u0.sum", int'(sa), 0);
        chk("rst.u1.sum", int'(sb), 0);
        #1 rst = 1'b0;
        #1;
        chk("rel.in_ready", int'(ir[0]), 1);

        // Back-to-back batch of 225s, single DRAIN cycle
        for (int i = 0; i < 4; i++) feed(0, 225);
        chk("b2b.out_valid", int'(ov[0]), 1);
        chk("b2b.sum", int'(sa), 900);
        chk("b2b.ovf", int'(of[0]), 0);
        chk("b2b.in_ready", int'(ir[0]), 0);
        feed(0, 5);
        chk("b2b.valid_drop", int'(ov[0]), 0);
        chk("b2b.cnt_after", int'(cn[0]), 0);
        feed(0, 5);
        chk("b2b.next_accept", int'(cn[0]), 1);
        flush(0);

        // Saturation on u1, then a clean batch
        for (int i = 0; i < 8; i++) feed(1, 225);
        chk("sat.sum", int'(sb), 1023);
        chk("sat.ovf", int'(of[1]), 1);
        cyc();
        for (int i = 1; i <= 8; i++) feed(1, i);
        chk("sat.next_sum", int'(sb), 36);
        chk("sat.next_ovf", int'(of[1]), 0);
        cyc();

        // Backpressure with upstream still offering 99
        ordy[0] = 1'b0;
        feed(0, 3); feed(0, 5); feed(0, 7); feed(0, 9);
        iv[0] = 1'b1;
        pr[0] = 8'd99;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("bp.sum", int'(sa), 24);
            chk("bp.in_ready", int'(ir[0]), 0);
        end
        ordy[0] = 1'b1;
        cyc();
        chk("bp.release_valid", int'(ov[0]), 0);
        chk("bp.release_cnt", int'(cn[0]), 0);
        cyc();
        chk("bp.accept_99", int'(cn[0]), 1);
        iv[0] = 1'b0;
        flush(0);

        // Gaps in in_valid; masked words carry random garbage
        for (int i = 0; i < 7; i++) begin
            iv[0] = gv[i][0];
            pr[0] = gv[i] ? 8'(gp[i]) : 8'($urandom_range(1, 255));
            cyc();
            if (i < 6) chk($sformatf("gap.cnt%0d", i), int'(cn[0]), gc[i]);
        end
        iv[0] = 1'b0;
        chk("gap.valid", int'(ov[0]), 1);
        chk("gap.sum", int'(sa), 100);
        cyc();

        // clear on the same cycle as a product
        feed(0, 50); feed(0, 60);
        clr[0] = 1'b1;
        feed(0, 70);
        clr[0] = 1'b0;
        chk("clr.cnt", int'(cn[0]), 0);
        chk("clr.valid", int'(ov[0]), 0);
        for (int i = 0; i < 4; i++) feed(0, 1);
        chk("clr.sum", int'(sa), 4);
        cyc();

        // Reset mid-batch and during a held DRAIN
        for (int i = 0; i < 3; i++) feed(0, 15);
        rst_pulse("arst_mid");
        ordy[0] = 1'b0;
        for (int i = 0; i < 4; i++) feed(0, 7);
        chk("arst.pre_valid", int'(ov[0]), 1);
        rst_pulse("arst_drain");
        ordy[0] = 1'b1;
        for (int i = 0; i < 4; i++) feed(0, 15);
        chk("arst.fresh_sum", int'(sa), 60);
        cyc();

        // Randomized traffic on both instances
        for (int n = 0; n < 800; n++) begin
            for (int k = 0; k < 2; k++) begin
                iv[k]   = ($urandom_range(0, 3) != 0);
                pr[k]   = 8'($urandom_range(0, 255));
                ordy[k] = ($urandom_range(0, 2) != 0);
                clr[k]  = ($urandom_range(0, 49) == 0);
            end
            cyc();
        end
        idle();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
